// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter. Execute, load and debug requesters share one
// registered write port. Ex/ld use round-robin, and debug has a starvation override.
module rf_wr_arbiter #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned STARVE_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              ex_valid,
   input  logic              ld_valid,
   input  logic              dbg_valid,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] ex_data,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              ex_ready,
   output logic              ld_ready,
   output logic              dbg_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [1:0]        grant_id,
   output logic [15:0]       conflict_cnt
);

   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
   localparam int unsigned CNT_W    = 16;
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      SRC_EX   = 2'd0,
      SRC_LD   = 2'd1,
      SRC_DBG  = 2'd2,
      SRC_NONE = 2'd3
   } src_e;

   // rr_last_q: 1 = load was the last ex/ld winner
   logic                rr_last_q, rr_last_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [CNT_W-1:0]    conf_q, conf_d;
   logic                rf_we_q, rf_we_d;
   logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
   src_e                gid_q, gid_d;

   src_e                sel;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic                dbg_force;
   logic                conflict;

   assign dbg_force = dbg_valid && (starve_q == STARVE_LIM);
   assign conflict  = (ex_valid && ld_valid) || (ex_valid && dbg_valid) || (ld_valid && dbg_valid);

   // Grant selection; nothing is granted in reset or while held
   always_comb begin
      sel = SRC_NONE;
      if (rst && !hold) begin
         if (dbg_force)                 sel = SRC_DBG;
         else if (ex_valid && ld_valid) sel = rr_last_q ? SRC_EX : SRC_LD;
         else if (ex_valid)             sel = SRC_EX;
         else if (ld_valid)             sel = SRC_LD;
         else if (dbg_valid)            sel = SRC_DBG;
      end
   end

   assign ex_ready  = (sel == SRC_EX);
   assign ld_ready  = (sel == SRC_LD);
   assign dbg_ready = (sel == SRC_DBG);

   always_comb begin
      sel_addr = ex_addr;
      sel_data = ex_data;
      case (sel)
         SRC_LD: begin
            sel_addr = ld_addr;
            sel_data = ld_data;
         end
         SRC_DBG: begin
            sel_addr = dbg_addr;
            sel_data = dbg_data;
         end
         default: ;
      endcase
   end

   // Next-state for pointer, counters and the registered write port
   always_comb begin
      rr_last_d  = rr_last_q;
      starve_d   = starve_q;
      conf_d     = conf_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      gid_d      = sel;

      if (sel == SRC_EX) rr_last_d = 1'b0;
      if (sel == SRC_LD) rr_last_d = 1'b1;

      if (!dbg_valid || dbg_ready)   starve_d = '0;
      else if (starve_q != STARVE_LIM) starve_d = starve_q + STARVE_W'(1);

      if (conflict && (conf_q != {CNT_W{1'b1}})) conf_d = conf_q + CNT_W'(1);

      // x0 is hardwired: the handshake completes but no write is issued
      if (sel != SRC_NONE) begin
         rf_we_d    = (sel_addr != '0);
         rf_waddr_d = sel_addr;
         rf_wdata_d = sel_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_last_q  <= 1'b1;
         starve_q   <= '0;
         conf_q     <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         gid_q      <= SRC_NONE;
      end else begin
         rr_last_q  <= rr_last_d;
         starve_q   <= starve_d;
         conf_q     <= conf_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         gid_q      <= gid_d;
      end
   end

   assign rf_we        = rf_we_q;
   assign rf_waddr     = rf_waddr_q;
   assign rf_wdata     = rf_wdata_q;
   assign grant_id     = gid_q;
   assign conflict_cnt = conf_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter. Expected writes are queued by the stimulus and
// checked by an independent write-port monitor.
module tb_rf_wr_arbiter;

   localparam logic [1:0] G_EX = 2'd0, G_LD = 2'd1, G_DBG = 2'd2, G_NONE = 2'd3;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [63:0] data;
      logic [1:0]  gid;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        hold;
   logic        ex_valid, ld_valid, dbg_valid;
   logic [4:0]  ex_addr, ld_addr, dbg_addr;
   logic [63:0] ex_data, ld_data, dbg_data;
   logic        ex_ready, ld_ready, dbg_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [1:0]  grant_id;
   logic [15:0] conflict_cnt;

   int  n_cmp = 0;
   int  n_err = 0;
   int  exp_conf = 0;
   wr_t exp_q[$];
   wr_t mon_r;

   rf_wr_arbiter #(.DATA_W(64), .ADDR_W(5), .STARVE_MAX(15)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .ex_valid(ex_valid), .ld_valid(ld_valid), .dbg_valid(dbg_valid),
      .ex_addr(ex_addr), .ld_addr(ld_addr), .dbg_addr(dbg_addr),
      .ex_data(ex_data), .ld_data(ld_data), .dbg_data(dbg_data),
      .ex_ready(ex_ready), .ld_ready(ld_ready), .dbg_ready(dbg_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .grant_id(grant_id), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] rdy_vec(input logic [1:0] g);
      case (g)
         G_EX:    return 3'b100;
         G_LD:    return 3'b010;
         G_DBG:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // One arbitration cycle: check grant g and queue the write it should produce
   task automatic step(input logic [1:0] g);
      wr_t r;
      @(negedge clk);
      chk("ready", {ex_ready, ld_ready, dbg_ready}, rdy_vec(g));
      chk("conflict_cnt", conflict_cnt, exp_conf);
      if (rst && (int'(ex_valid) + int'(ld_valid) + int'(dbg_valid) >= 2)) exp_conf++;
      if (g != G_NONE) begin
         r.gid = g;
         case (g)
            G_EX:    begin r.addr = ex_addr;  r.data = ex_data;  end
            G_LD:    begin r.addr = ld_addr;  r.data = ld_data;  end
            default: begin r.addr = dbg_addr; r.data = dbg_data; end
         endcase
         r.we = (r.addr != 5'd0);
         exp_q.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   // Write-port monitor
   always @(negedge clk) begin
      if (grant_id != G_NONE) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: grant_id %0d addr %0d, expected no write", grant_id, rf_waddr);
         end else begin
            mon_r = exp_q.pop_front();
            chk("wr_gid",  grant_id, mon_r.gid);
            chk("wr_we",   rf_we,    mon_r.we);
            chk("wr_addr", rf_waddr, mon_r.addr);
            chk("wr_data", rf_wdata, mon_r.data);
         end
      end else begin
         chk("idle_we", rf_we, 1'b0);
      end
   end

   initial begin
      rst = 1'b1; hold = 1'b0;
      ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 64'h11;
      ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 64'h22;
      dbg_valid = 1'b1; dbg_addr = 5'd5; dbg_data = 64'h33;
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset with every requester valid
      step(G_NONE);
      step(G_NONE);
      chk("rst_we", rf_we, 1'b0);
      chk("rst_gid", grant_id, G_NONE);
      chk("rst_waddr", rf_waddr, 5'd0);
      chk("rst_starve", dut.starve_q, 0);

      // Release; ex wins the first tie, then strict alternation
      dbg_valid = 1'b0;
      rst = 1'b1;
      step(G_EX);
      step(G_LD);
      step(G_EX);
      step(G_LD);

      // Debug starved for 15 cycles, forced on the 16th, and ld is next after that
      dbg_valid = 1'b1;
      for (int i = 0; i < 15; i++) step((i % 2 == 0) ? G_EX : G_LD);
      step(G_DBG);
      chk("starve_after_force", dut.starve_q, 0);
      step(G_LD);
      step(G_EX);
      dbg_valid = 1'b0;
      ex_valid = 1'b0;

      // Write to x0 followed by a normal write
      ld_addr = 5'd0; ld_data = 64'hDEAD;
      step(G_LD);
      ld_addr = 5'd7; ld_data = 64'h77;
      step(G_LD);
      ld_valid = 1'b0;

      // Hold blocks the grant for three cycles
      ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 64'h11;
      hold = 1'b1;
      step(G_NONE);
      step(G_NONE);
      step(G_NONE);
      hold = 1'b0;
      step(G_EX);
      ex_valid = 1'b0;
      step(G_NONE);

      // Async reset while a write sits on the port
      ex_valid = 1'b1; ex_addr = 5'd9; ex_data = 64'h99;
      dbg_valid = 1'b1;
      @(negedge clk);
      chk("pre_rst_ready", {ex_ready, ld_ready, dbg_ready}, 3'b100);
      @(posedge clk);
      #1;
      chk("pre_rst_we", rf_we, 1'b1);
      chk("pre_rst_addr", rf_waddr, 5'd9);
      #2 rst = 1'b0;
      #1;
      chk("async_we", rf_we, 1'b0);
      chk("async_gid", grant_id, G_NONE);
      chk("async_ready", {ex_ready, ld_ready, dbg_ready}, 3'b000);
      exp_conf = 0;
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      dbg_valid = 1'b0;
      rst = 1'b1;
      chk("post_rst_starve", dut.starve_q, 0);
      chk("post_rst_conflict", conflict_cnt, 16'd0);

      // Pointer is back at its reset value, so ex wins the tie again
      ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 64'h1;
      ld_valid = 1'b1; ld_addr = 5'd4; ld_data = 64'h22;
      step(G_EX);
      step(G_LD);
      ex_valid = 1'b0;
      ld_valid = 1'b0;
      step(G_NONE);
      step(G_NONE);

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
